// File: rtl/memfifo_rd_scheduler.sv
// Read scheduler for the memory FIFO: queues up to four packet-count requests
// and, once data_ready is seen, issues paced memfifo_re pulses (two per packet).
module memfifo_rd_scheduler #(
  parameter int unsigned EXTRA_DELAY = 11,
  parameter int unsigned DELAY_BIT   = 3,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_packet_no,
  output logic        req_ready,
  input  logic        data_ready,
  input  logic        abort,
  output logic        memfifo_re,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] pkt_sent,
  output logic [2:0]  queue_level
);

  localparam int unsigned PKT_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LVL_W = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned DEPTH = 4;

  // Last count value of each timed state; the shared counter restarts at 0 on entry.
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(EXTRA_DELAY - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((1 << DELAY_BIT) - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_DELAY,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PKT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PKT_W-1:0] target;
  logic [PKT_W-1:0] target_nxt;
  logic [PKT_W-1:0] pkt_sent_nxt;
  logic [PKT_W-1:0] pkt_inc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             push;
  logic             pop;
  logic             timeout_hit;
  logic             re_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             timeout_nxt;
  logic             ready_nxt;

  assign push    = req_valid && req_ready;
  assign pop     = (state == S_IDLE) && (queue_level != '0);
  assign pkt_inc = pkt_sent + PKT_W'(1);

  // Request storage; contents need no reset because level/pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= req_packet_no;
    end
  end

  always_comb begin
    level_nxt = queue_level;
    case ({push, pop})
      2'b10:   level_nxt = queue_level + LVL_W'(1);
      2'b01:   level_nxt = queue_level - LVL_W'(1);
      default: level_nxt = queue_level;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks every other transition, including timeout.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) state_nxt = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (target == '0) begin
          state_nxt = S_DONE;
        end else if (data_ready) begin
          state_nxt = (EXTRA_DELAY == 0) ? S_PULSE : S_DELAY;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt == DELAY_LAST) state_nxt = S_PULSE;
      end
      S_PULSE: begin
        state_nxt = (pkt_inc == target) ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_PULSE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt   = S_IDLE;
      timeout_hit = 1'b0;
    end
  end

  // Output/datapath next values; flags are taken from the next state so each
  // registered output lines up exactly with the state it describes.
  always_comb begin
    cnt_nxt      = '0;
    target_nxt   = target;
    pkt_sent_nxt = pkt_sent;
    if ((state_nxt == state) && (state != S_IDLE)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    if (pop) begin
      target_nxt   = PKT_W'(fifo_mem[rd_ptr] << 1);
      pkt_sent_nxt = '0;
    end else if (state == S_PULSE) begin
      pkt_sent_nxt = pkt_inc;
    end
    re_nxt      = (state_nxt == S_PULSE);
    busy_nxt    = (state_nxt != S_IDLE);
    done_nxt    = (state_nxt == S_DONE);
    timeout_nxt = timeout_hit;
    ready_nxt   = (level_nxt != LVL_FULL);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      target      <= '0;
      pkt_sent    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
      req_ready   <= 1'b1;
      memfifo_re  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      target      <= target_nxt;
      pkt_sent    <= pkt_sent_nxt;
      queue_level <= level_nxt;
      req_ready   <= ready_nxt;
      memfifo_re  <= re_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      timeout_err <= timeout_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: doc/memfifo_rd_scheduler.md
MEMFIFO_RD_SCHEDULER -- requirements
Module: memfifo_rd_scheduler

Interface
REQ-001 SHALL have parameter EXTRA_DELAY, default 11, meaning clocks from data_ready acceptance to first memfifo_re (0 allowed).
REQ-002 SHALL have parameter DELAY_BIT, default 3, meaning memfifo_re period of 2**DELAY_BIT clocks (range 1..8).
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning max clocks waiting for data_ready (range 1..65535).
REQ-004 SHALL have ports clk, in, 1, sole clock; rst, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports req_valid, in, 1, request offered; req_packet_no, in, 16, packet count; req_ready, out, 1, queue not full.
REQ-006 SHALL have ports data_ready, in, 1, memfifo data ready; abort, in, 1, synchronous cancel of active request.
REQ-007 SHALL have ports memfifo_re, out, 1, read pulse; busy, out, 1, FSM not IDLE; done, out, 1, request-complete pulse; timeout_err, out, 1, timeout pulse.
REQ-008 SHALL have ports pkt_sent, out, 16, pulses issued for active request; queue_level, out, 3, queued requests (0..4).

Function
REQ-009 SHALL buffer requests in a 4-entry FIFO; push when req_valid && req_ready; req_ready = (queue_level != 4), driven from a flop.
REQ-010 SHALL, on simultaneous push and pop, perform both, leaving queue_level unchanged and order preserved.
REQ-011 SHALL implement FSM states IDLE, WAIT_READY, DELAY, PULSE, GAP, DONE; memfifo_re = 1 exactly in PULSE cycles, driven from a flop.
REQ-012 IDLE: if queue non-empty, pop head, load target = packet_no << 1 (16-bit, MSB dropped), clear pkt_sent, go WAIT_READY next cycle.
REQ-013 WAIT_READY: data_ready sampled high -> DELAY (PULSE if EXTRA_DELAY=0); data_ready ignored in all other states.
REQ-014 WAIT_READY: target = 0 -> DONE next cycle regardless of data_ready; no memfifo_re issued.
REQ-015 WAIT_READY: data_ready low for TIMEOUT consecutive cycles -> IDLE with timeout_err high one cycle; data_ready high in the final counted cycle wins (no timeout).
REQ-016 DELAY: remain exactly EXTRA_DELAY cycles, then PULSE; first memfifo_re EXTRA_DELAY+1 cycles after data_ready sampled.
REQ-017 PULSE: one cycle, pkt_sent += 1; if new pkt_sent == target -> DONE, else GAP for 2**DELAY_BIT - 1 cycles, then PULSE.
REQ-018 DONE: done high one cycle, then IDLE; next pop no earlier than the cycle after DONE.
REQ-019 abort high in any non-IDLE state -> IDLE next cycle, memfifo_re low, no done, no timeout_err; queue contents kept; abort in IDLE ignored.
REQ-020 abort and timeout in same cycle -> abort wins, timeout_err stays low.
REQ-021 pkt_sent SHALL hold its final value after DONE/abort until the next pop.
REQ-022 busy SHALL be high in every state except IDLE.

Reset
REQ-023 rst high SHALL immediately force IDLE, empty queue, queue_level=0, req_ready=1, memfifo_re=0, busy=0, done=0, timeout_err=0, pkt_sent=0, counters=0.
REQ-024 rst asserted mid-request SHALL drop the active and queued requests; no done after release.
REQ-025 first push SHALL be accepted in the first clock edge after rst deasserts.

Verification
REQ-026 Defaults, push packet_no=3, data_ready high at cycle W -> memfifo_re at W+12, W+20, ..., W+52 (6 pulses), done at W+53, pkt_sent=6.
REQ-027 Push packet_no=0 -> no memfifo_re, done 2 cycles after pop, pkt_sent=0.
REQ-028 TIMEOUT=16, data_ready held low -> timeout_err one cycle after 16th WAIT_READY cycle, busy=0; next queued request then pops.
REQ-029 Push 6 requests back-to-back while first is in WAIT_READY -> queue_level reaches 4, req_ready=0, 6th held until pop, all served in order.
REQ-030 abort after 3rd pulse of packet_no=2 -> memfifo_re low next cycle, pkt_sent=3, no done; queued request proceeds.
REQ-031 rst pulse during GAP with 2 queued -> all outputs at reset values, queue_level=0, no further memfifo_re.
